// File: rtl/attn_rr_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : attn_pkg
// Description : Shared types and Q8.8 constants for the attention scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package attn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_t;

  localparam logic [15:0] Q_ONE           = 16'h0100;
  localparam int          Q_FRAC          = 8;
  localparam int          DEFAULT_TIMEOUT = 15;

endpackage
`default_nettype wire

// File: rtl/attn_rr_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : attn_rr_scheduler_if
// Description : Requester, core and response bundles of the attention scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface attn_rr_scheduler_if #(
  parameter int NREQ = 4,
  parameter int N    = 4,
  parameter int DW   = 16
);
  localparam int IDW = $clog2(NREQ);

  logic        [NREQ-1:0]                 req_valid;
  logic        [NREQ-1:0]                 req_ready;
  logic signed [NREQ-1:0][N-1:0][DW-1:0]  req_q;
  logic signed [NREQ-1:0][N-1:0][DW-1:0]  req_k;
  logic signed [NREQ-1:0][N-1:0][DW-1:0]  req_v;

  logic                                   core_start;
  logic signed [N-1:0][DW-1:0]            core_q;
  logic signed [N-1:0][DW-1:0]            core_k;
  logic signed [N-1:0][DW-1:0]            core_v;
  logic                                   core_done;
  logic signed [DW-1:0]                   core_y;

  logic                                   rsp_valid;
  logic                                   rsp_ready;
  logic        [IDW-1:0]                  rsp_id;
  logic signed [DW-1:0]                   rsp_y;
  logic                                   rsp_timeout;
  logic                                   busy;
  logic                                   stray_done;

  // Scheduler side
  modport slave (
    input  req_valid, req_q, req_k, req_v, core_done, core_y, rsp_ready,
    output req_ready, core_start, core_q, core_k, core_v,
           rsp_valid, rsp_id, rsp_y, rsp_timeout, busy, stray_done
  );

  // Producers, core and consumer side
  modport master (
    output req_valid, req_q, req_k, req_v, core_done, core_y, rsp_ready,
    input  req_ready, core_start, core_q, core_k, core_v,
           rsp_valid, rsp_id, rsp_y, rsp_timeout, busy, stray_done
  );

endinterface
`default_nettype wire

// File: rtl/attn_rr_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick, searching upward from ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_idx,
  output logic                    any_req
);

  int                      w_pos;
  logic [$clog2(NREQ)-1:0] w_idx;

  // Walk offsets from far to near so the closest requester after ptr wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_req   = |req;
    w_pos     = 0;
    w_idx     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_pos = int'(ptr) + k;
      if (w_pos >= NREQ) w_pos = w_pos - NREQ;
      w_idx = w_pos[$clog2(NREQ)-1:0];
      if (req[w_idx]) begin
        grant        = '0;
        grant[w_idx] = 1'b1;
        grant_idx    = w_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/attn_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : attn_rr_scheduler
// Description : Round-robin sharing of one attention core among NREQ requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module attn_rr_scheduler
  import attn_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int N       = 4,
  parameter int DW      = 16,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input logic                 clk,
  input logic                 rst,
  attn_rr_scheduler_if.slave  bus
);

  localparam int IDW = $clog2(NREQ);

  sched_state_t                r_state;
  logic [IDW-1:0]              r_ptr;
  logic [IDW-1:0]              r_gnt_id;
  logic [7:0]                  r_cnt;
  logic                        r_gap;
  logic                        r_core_start;
  logic signed [N-1:0][DW-1:0] r_core_q;
  logic signed [N-1:0][DW-1:0] r_core_k;
  logic signed [N-1:0][DW-1:0] r_core_v;
  logic                        r_rsp_valid;
  logic [IDW-1:0]              r_rsp_id;
  logic signed [DW-1:0]        r_rsp_y;
  logic                        r_rsp_timeout;
  logic                        r_stray;

  logic [NREQ-1:0]             w_grant;
  logic [IDW-1:0]              w_gnt_idx;
  logic                        w_any_req;
  logic                        w_accept;
  logic [7:0]                  w_cnt_next;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req       (bus.req_valid),
    .ptr       (r_ptr),
    .grant     (w_grant),
    .grant_idx (w_gnt_idx),
    .any_req   (w_any_req)
  );

  // One dead IDLE cycle after every response sets the accept cadence to L+4.
  assign w_accept   = (r_state == IDLE) && !r_gap && w_any_req && !rst;
  assign w_cnt_next = r_cnt + 8'd1;

  assign bus.req_ready   = w_accept ? w_grant : '0;
  assign bus.busy        = (r_state != IDLE);
  assign bus.core_start  = r_core_start;
  assign bus.core_q      = r_core_q;
  assign bus.core_k      = r_core_k;
  assign bus.core_v      = r_core_v;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_id      = r_rsp_id;
  assign bus.rsp_y       = r_rsp_y;
  assign bus.rsp_timeout = r_rsp_timeout;
  assign bus.stray_done  = r_stray;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_ptr         <= '0;
      r_gnt_id      <= '0;
      r_cnt         <= '0;
      r_gap         <= 1'b0;
      r_core_start  <= 1'b0;
      r_core_q      <= '0;
      r_core_k      <= '0;
      r_core_v      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_id      <= '0;
      r_rsp_y       <= '0;
      r_rsp_timeout <= 1'b0;
      r_stray       <= 1'b0;
    end else begin
      r_core_start <= 1'b0;
      if (bus.core_done && (r_state != WAIT)) r_stray <= 1'b1;

      case (r_state)
        IDLE: begin
          r_gap <= 1'b0;
          if (w_accept) begin
            r_core_q     <= bus.req_q[w_gnt_idx];
            r_core_k     <= bus.req_k[w_gnt_idx];
            r_core_v     <= bus.req_v[w_gnt_idx];
            r_gnt_id     <= w_gnt_idx;
            r_core_start <= 1'b1;
            r_state      <= ISSUE;
          end
        end
        ISSUE: begin
          r_cnt   <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          r_cnt <= w_cnt_next;
          // A done arriving on the expiry cycle still delivers real data.
          if (bus.core_done) begin
            r_rsp_y       <= bus.core_y;
            r_rsp_timeout <= 1'b0;
            r_rsp_id      <= r_gnt_id;
            r_rsp_valid   <= 1'b1;
            r_state       <= RESP;
          end else if (w_cnt_next == 8'(TIMEOUT)) begin
            r_rsp_y       <= '0;
            r_rsp_timeout <= 1'b1;
            r_rsp_id      <= r_gnt_id;
            r_rsp_valid   <= 1'b1;
            r_state       <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_ptr       <= (r_gnt_id == IDW'(NREQ - 1)) ? '0 : r_gnt_id + IDW'(1);
            r_gap       <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_attn_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_attn_rr_scheduler
// Description : Directed bench for attn_rr_scheduler with an L-cycle stub core.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_attn_rr_scheduler;
  import attn_pkg::*;

  localparam int NREQ    = 4;
  localparam int N       = 4;
  localparam int DW      = 16;
  localparam int TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  int            checks   = 0;
  int            failures = 0;
  int            cyc      = 0;
  int            stub_lat = 3;
  int            stub_cnt;
  logic [DW-1:0] stub_y   = '0;
  logic          manual_done = 1'b0;

  attn_rr_scheduler_if #(.NREQ(NREQ), .N(N), .DW(DW)) bus ();

  attn_rr_scheduler #(.NREQ(NREQ), .N(N), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub core: done is high exactly stub_lat cycles after the start pulse; 0 = never.
  always @(posedge clk or posedge rst) begin
    if (rst)                 stub_cnt <= 0;
    else if (bus.core_start) stub_cnt <= stub_lat;
    else if (stub_cnt > 0)   stub_cnt <= stub_cnt - 1;
  end
  assign bus.core_done = (stub_cnt == 1) || manual_done;
  assign bus.core_y    = stub_y;

  function automatic logic [N-1:0][DW-1:0] pat_vec(int base, int i);
    logic [N-1:0][DW-1:0] v;
    for (int j = 0; j < N; j++) v[j] = DW'(base + i * 16 + j);
    return v;
  endfunction

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_operands;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_q[i] = pat_vec('h1000, i);
      bus.req_k[i] = pat_vec('h2000, i);
      bus.req_v[i] = pat_vec('h3000, i);
    end
  endtask

  // Returns the granted index in the cycle req_ready is seen, or -1 after 40 cycles.
  task automatic wait_accept(output int idx);
    idx = -1;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (bus.req_ready != '0) begin
        for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) idx = i;
        return;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.req_valid = '1;
    bus.rsp_ready = 1'b0;
    set_operands();
    step(2);
    checks++;
    if (bus.req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL reset_req_ready got=%b exp=0000", bus.req_ready);
    end
    checks++;
    if ({bus.busy, bus.core_start, bus.rsp_valid, bus.rsp_timeout, bus.stray_done} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=00000",
               {bus.busy, bus.core_start, bus.rsp_valid, bus.rsp_timeout, bus.stray_done});
    end
    checks++;
    if ({bus.rsp_y, bus.rsp_id} !== 18'h0 || {bus.core_q, bus.core_k, bus.core_v} !== '0) begin
      failures++;
      $display("FAIL reset_data rsp_y=%h rsp_id=%0d core_q=%h exp=0", bus.rsp_y, bus.rsp_id, bus.core_q);
    end
    bus.req_valid = '0;
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_single;
    int idx;
    for (int j = 0; j < N; j++) begin
      bus.req_q[2][j] = Q_ONE;
      bus.req_k[2][j] = Q_ONE;
      bus.req_v[2][j] = Q_ONE;
    end
    stub_lat = 3;
    stub_y = 16'h0180;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0100;
    wait_accept(idx);
    checks++;
    if (idx !== 2) begin
      failures++;
      $display("FAIL single_grant got=%0d exp=2", idx);
    end
    step(1);
    bus.req_valid = '0;
    checks++;
    if (bus.core_start !== 1'b1) begin
      failures++;
      $display("FAIL single_core_start got=%b exp=1", bus.core_start);
    end
    checks++;
    if (bus.core_q !== {N{Q_ONE}} || bus.core_k !== {N{Q_ONE}} || bus.core_v !== {N{Q_ONE}}) begin
      failures++;
      $display("FAIL single_operands q=%h k=%h v=%h exp=%h", bus.core_q, bus.core_k, bus.core_v, {N{Q_ONE}});
    end
    step(3);
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.core_start !== 1'b0) begin
      failures++;
      $display("FAIL single_early_rsp rsp_valid=%b core_start=%b exp=0 0", bus.rsp_valid, bus.core_start);
    end
    step(1);
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.rsp_timeout} !== {1'b1, 2'd2, 16'h0180, 1'b0}) begin
      failures++;
      $display("FAIL single_rsp valid=%b id=%0d y=%h to=%b exp=1 2 0180 0",
               bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.rsp_timeout);
    end
    step(1);
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL single_release rsp_valid=%b busy=%b exp=0 0", bus.rsp_valid, bus.busy);
    end
  endtask

  task automatic test_round_robin;
    int idx, t, prev;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    set_operands();
    stub_lat = 3;
    stub_y = 16'h0200;
    bus.rsp_ready = 1'b1;
    bus.req_valid = '1;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_accept(idx);
      t = cyc;
      checks++;
      if (idx !== k % NREQ) begin
        failures++;
        $display("FAIL rr_order step=%0d got=%0d exp=%0d", k, idx, k % NREQ);
      end
      if (k > 0) begin
        checks++;
        if (t - prev !== 7) begin
          failures++;
          $display("FAIL rr_spacing step=%0d got=%0d exp=7", k, t - prev);
        end
      end
      prev = t;
      step(1);
      checks++;
      if (bus.core_start !== 1'b1 || bus.core_v !== pat_vec('h3000, k % NREQ)) begin
        failures++;
        $display("FAIL rr_issue step=%0d start=%b v=%h exp=1 %h",
                 k, bus.core_start, bus.core_v, pat_vec('h3000, k % NREQ));
      end
    end
    bus.req_valid = '0;
    step(8);
  endtask

  task automatic test_timeout;
    int idx;
    bit seen;
    stub_lat = 0;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0010;
    wait_accept(idx);
    checks++;
    if (idx !== 1) begin
      failures++;
      $display("FAIL to_grant got=%0d exp=1", idx);
    end
    step(1);
    bus.req_valid = '0;
    step(15);
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL to_early got=%b exp=0", bus.rsp_valid);
    end
    step(1);
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.rsp_timeout} !== {1'b1, 2'd1, 16'h0000, 1'b1}) begin
      failures++;
      $display("FAIL to_rsp valid=%b id=%0d y=%h to=%b exp=1 1 0000 1",
               bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.rsp_timeout);
    end
    step(1);
    stub_lat = 3;
    stub_y = 16'h8001;
    bus.req_valid = 4'b1000;
    wait_accept(idx);
    checks++;
    if (idx !== 3) begin
      failures++;
      $display("FAIL to_next_grant got=%0d exp=3", idx);
    end
    step(1);
    bus.req_valid = '0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      step(1);
      if (bus.rsp_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || {bus.rsp_id, bus.rsp_y, bus.rsp_timeout} !== {2'd3, 16'h8001, 1'b0}) begin
      failures++;
      $display("FAIL to_next_rsp seen=%b id=%0d y=%h to=%b exp=1 3 8001 0",
               seen, bus.rsp_id, bus.rsp_y, bus.rsp_timeout);
    end
    step(2);
  endtask

  task automatic test_backpressure;
    int idx;
    stub_lat = 3;
    stub_y = 16'h7ff0;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0001;
    wait_accept(idx);
    checks++;
    if (idx !== 0) begin
      failures++;
      $display("FAIL bp_grant got=%0d exp=0", idx);
    end
    step(1);
    bus.req_valid = '1;
    step(4);
    for (int c = 0; c < 10; c++) begin
      checks++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.rsp_timeout, bus.req_ready, bus.core_start}
          !== {1'b1, 2'd0, 16'h7ff0, 1'b0, 4'b0000, 1'b0}) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d valid=%b id=%0d y=%h to=%b ready=%b start=%b exp=1 0 7ff0 0 0000 0",
                 c, bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.rsp_timeout, bus.req_ready, bus.core_start);
      end
      step(1);
    end
    bus.rsp_ready = 1'b1;
    step(1);
    checks++;
    if ({bus.busy, bus.rsp_valid, bus.req_ready} !== 6'b0) begin
      failures++;
      $display("FAIL bp_release busy=%b valid=%b ready=%b exp=0 0 0000", bus.busy, bus.rsp_valid, bus.req_ready);
    end
    bus.req_valid = '0;
    step(2);
  endtask

  task automatic test_collision_stray;
    int idx;
    stub_lat = 15;
    stub_y = 16'h0abc;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0010;
    wait_accept(idx);
    checks++;
    if (idx !== 1) begin
      failures++;
      $display("FAIL col_grant got=%0d exp=1", idx);
    end
    step(1);
    bus.req_valid = '0;
    step(15);
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL col_early got=%b exp=0", bus.rsp_valid);
    end
    step(1);
    checks++;
    if ({bus.rsp_valid, bus.rsp_y, bus.rsp_timeout, bus.stray_done} !== {1'b1, 16'h0abc, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL col_rsp valid=%b y=%h to=%b stray=%b exp=1 0abc 0 0",
               bus.rsp_valid, bus.rsp_y, bus.rsp_timeout, bus.stray_done);
    end
    step(3);
    manual_done = 1'b1;
    step(1);
    manual_done = 1'b0;
    checks++;
    if (bus.stray_done !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL stray_set stray=%b rsp_valid=%b exp=1 0", bus.stray_done, bus.rsp_valid);
    end
    step(5);
    checks++;
    if (bus.stray_done !== 1'b1) begin
      failures++;
      $display("FAIL stray_sticky got=%b exp=1", bus.stray_done);
    end
  endtask

  task automatic test_reset_mid_wait;
    int idx;
    stub_lat = 10;
    bus.rsp_ready = 1'b1;
    bus.req_valid = '1;
    wait_accept(idx);
    checks++;
    if (idx !== 2) begin
      failures++;
      $display("FAIL rmw_grant got=%0d exp=2", idx);
    end
    step(1);
    checks++;
    if (bus.core_start !== 1'b1) begin
      failures++;
      $display("FAIL rmw_start got=%b exp=1", bus.core_start);
    end
    step(2);
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.core_start, bus.rsp_valid, bus.rsp_timeout, bus.stray_done, bus.req_ready} !== 9'b0 ||
        {bus.rsp_y, bus.rsp_id} !== 18'h0 || bus.core_q !== '0) begin
      failures++;
      $display("FAIL rmw_async busy=%b start=%b valid=%b stray=%b ready=%b y=%h id=%0d q=%h exp=all 0",
               bus.busy, bus.core_start, bus.rsp_valid, bus.stray_done, bus.req_ready,
               bus.rsp_y, bus.rsp_id, bus.core_q);
    end
    step(2);
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL rmw_hold rsp_valid=%b busy=%b exp=0 0", bus.rsp_valid, bus.busy);
    end
    rst = 1'b0;
    wait_accept(idx);
    checks++;
    if (idx !== 0) begin
      failures++;
      $display("FAIL rmw_regrant got=%0d exp=0", idx);
    end
    step(1);
    bus.req_valid = '0;
    step(2);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_backpressure();
    test_collision_stray();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
`default_nettype wire
